// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite slave register file.
// Holds the response codes, the strobe width and the read-channel FSM
// state type used by axi4_lite_slave_regfile and axi4_lite_regfile_mem.
package axi4_lite_pkg;

  localparam int STRB_WIDTH = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Read channel: R_IDLE accepts AR, R_DATA presents the R beat.
  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi4_lite_regfile_mem.sv
// NUM_REGS x DATA_WIDTH register array.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset (clears array and rd_data)
//   wr_en/wr_idx/wr_data/wr_strb : byte-enabled write port
//   rd_en/rd_idx/rd_zero : synchronous read port; rd_zero loads 0 instead of the array word
//   rd_data             : registered read data, holds its value until the next rd_en
// A read and a write to the same index on the same edge return the old word.
module axi4_lite_regfile_mem
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (wr_strb[b]) begin
            regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
      if (rd_en) begin
        rd_data <= rd_zero ? '0 : regs[rd_idx];
      end
    end
  end

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave terminating writes and reads into a word-addressed
// register file of NUM_REGS 32-bit registers.
// Ports:
//   aclk, aresetn         : clock, synchronous active-low reset
//   aw*_in/awready_out    : write address channel
//   w*_in/wready_out      : write data channel (4 byte strobes)
//   bresp_out/bvalid_out/bready_in : write response channel
//   ar*_in/arready_out    : read address channel
//   rdata_out/rresp_out/rvalid_out/rready_in : read data channel
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a source holds valid and payload stable until that edge, and
// this slave holds bvalid/bresp and rvalid/rdata/rresp stable until accepted.
// Optional macro AXI4_LITE_SLAVE_PROT_CHECK_EN: register 0 becomes privileged;
// accesses to it with prot[0] = 0 are refused with SLVERR.
module axi4_lite_slave_regfile
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] awaddr_in,
  input  logic [2:0]            awprot_in,
  input  logic                  awvalid_in,
  output logic                  awready_out,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic [STRB_WIDTH-1:0] wstrb_in,
  input  logic                  wvalid_in,
  output logic                  wready_out,
  output logic [1:0]            bresp_out,
  output logic                  bvalid_out,
  input  logic                  bready_in,
  input  logic [ADDR_WIDTH-1:0] araddr_in,
  input  logic [2:0]            arprot_in,
  input  logic                  arvalid_in,
  output logic                  arready_out,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic [1:0]            rresp_out,
  output logic                  rvalid_out,
  input  logic                  rready_in
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

  // ---------------- write path ----------------
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [2:0]            aw_prot_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [2:0]            wr_prot;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_in_range;
  logic                  wr_ok;

  assign awready_out = !aw_held && !bvalid_out;
  assign wready_out  = !w_held && !bvalid_out;
  assign aw_hs       = awvalid_in && awready_out;
  assign w_hs        = wvalid_in && wready_out;

  // Each half comes from its hold register if it arrived earlier,
  // otherwise straight from the bus in the handshake cycle.
  assign wr_addr = aw_held ? aw_addr_q : awaddr_in;
  assign wr_prot = aw_held ? aw_prot_q : awprot_in;
  assign wr_data = w_held ? w_data_q : wdata_in;
  assign wr_strb = w_held ? w_strb_q : wstrb_in;

  assign commit      = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_idx      = wr_addr[IDX_W+1:2];
  assign wr_in_range = (wr_addr < ADDR_LIMIT);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_addr_q  <= '0;
      aw_prot_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_out <= 1'b0;
      bresp_out  <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_held    <= 1'b0;
        w_held     <= 1'b0;
        bvalid_out <= 1'b1;
        bresp_out  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= awaddr_in;
          aw_prot_q <= awprot_in;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= wdata_in;
          w_strb_q <= wstrb_in;
        end
        if (bvalid_out && bready_in) begin
          bvalid_out <= 1'b0;
        end
      end
    end
  end

  // ---------------- read path ----------------
  rd_state_e        rd_state;
  logic             ar_hs;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range;
  logic             rd_ok;

  assign arready_out = (rd_state == R_IDLE);
  assign rvalid_out  = (rd_state == R_DATA);
  assign ar_hs       = arvalid_in && arready_out;
  assign rd_idx      = araddr_in[IDX_W+1:2];
  assign rd_in_range = (araddr_in < ADDR_LIMIT);

`ifdef AXI4_LITE_SLAVE_PROT_CHECK_EN
  assign wr_ok = wr_in_range && !((wr_idx == '0) && !wr_prot[0]);
  assign rd_ok = rd_in_range && !((rd_idx == '0) && !arprot_in[0]);
`else
  assign wr_ok = wr_in_range;
  assign rd_ok = rd_in_range;
`endif

  // Protection bits are only consulted when the privileged-register check is built in.
  logic unused_prot;
  assign unused_prot = ^{wr_prot, arprot_in};

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state  <= R_IDLE;
      rresp_out <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state  <= R_DATA;
            rresp_out <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        R_DATA: begin
          if (rready_in) begin
            rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // rdata_out is the memory's registered read port: it loads only on the
  // AR handshake, so it is stable for the whole R beat.
  axi4_lite_regfile_mem #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (commit && wr_ok),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_en   (ar_hs),
    .rd_zero (!rd_ok),
    .rd_idx  (rd_idx),
    .rd_data (rdata_out)
  );

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Self-checking bench for axi4_lite_slave_regfile (NUM_REGS = 16).
// Expected values come from a register-array model updated by the
// address/strobe/protection rules; read data goes through exp_q.
module tb_axi4_lite_slave_regfile;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  axi4_lite_slave_regfile #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (16)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .awaddr_in   (awaddr),
    .awprot_in   (awprot),
    .awvalid_in  (awvalid),
    .awready_out (awready),
    .wdata_in    (wdata),
    .wstrb_in    (wstrb),
    .wvalid_in   (wvalid),
    .wready_out  (wready),
    .bresp_out   (bresp),
    .bvalid_out  (bvalid),
    .bready_in   (bready),
    .araddr_in   (araddr),
    .arprot_in   (arprot),
    .arvalid_in  (arvalid),
    .arready_out (arready),
    .rdata_out   (rdata),
    .rresp_out   (rresp),
    .rvalid_out  (rvalid),
    .rready_in   (rready)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] model_regs [16];
  logic [31:0] exp_q [$];
  logic [1:0]  exp_resp_q [$];

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb, input logic [2:0] prot);
    int idx;
    if (addr >= 32'd64) return SLVERR;
    idx = int'(addr / 4);
`ifdef AXI4_LITE_SLAVE_PROT_CHECK_EN
    if (idx == 0 && prot[0] == 1'b0) return SLVERR;
`endif
    for (int b = 0; b < 4; b++)
      if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
    return OKAY;
  endfunction

  function automatic void model_read(input logic [31:0] addr, input logic [2:0] prot,
                                     output logic [31:0] data, output logic [1:0] resp);
    int idx;
    data = '0;
    resp = SLVERR;
    if (addr < 32'd64) begin
      idx = int'(addr / 4);
      resp = OKAY;
      data = model_regs[idx];
`ifdef AXI4_LITE_SLAVE_PROT_CHECK_EN
      if (idx == 0 && prot[0] == 1'b0) begin
        resp = SLVERR;
        data = '0;
      end
`endif
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge aclk);
    aresetn = 0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1;
    for (int i = 0; i < 16; i++) model_regs[i] = '0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [2:0] prot, input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp_got);
    logic [1:0] exp_resp;
    bit aw_done = 0, w_done = 0, hs_aw, hs_w, stall_bad = 0, early_b = 0, hold_bad = 0;
    int cyc = 0;
    exp_resp = model_write(addr, data, strb, prot);
    awaddr = addr; awprot = prot; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge aclk);
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      if ((aw_done && awready) || (w_done && wready)) stall_bad = 1;
      if (bvalid) early_b = 1;
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge aclk);
      if (hs_aw) aw_done = 1;
      if (hs_w) w_done = 1;
      cyc++;
    end
    @(negedge aclk);
    awvalid = 0; wvalid = 0; bready = 0;
    checks++;
    if (!(aw_done && w_done)) begin
      errors++;
      $display("FAIL wr_timeout addr=%h aw_done=%0d w_done=%0d required both 1", addr, aw_done, w_done);
    end
    checks++;
    if (stall_bad || early_b) begin
      errors++;
      $display("FAIL wr_ready_stall addr=%h stall=%0d early_b=%0d required 0 0", addr, stall_bad, early_b);
    end
    checks++;
    if (bvalid !== 1'b1 || bresp !== exp_resp) begin
      errors++;
      $display("FAIL wr_b_latency addr=%h bvalid=%b bresp=%b required 1 %b", addr, bvalid, bresp, exp_resp);
    end
    resp_got = bresp;
    for (int i = 0; i < b_dly; i++) begin
      @(posedge aclk);
      @(negedge aclk);
      if (bvalid !== 1'b1 || bresp !== exp_resp || awready !== 1'b0 || wready !== 1'b0) hold_bad = 1;
    end
    checks++;
    if (hold_bad) begin
      errors++;
      $display("FAIL wr_b_hold addr=%h bvalid/bresp/awready/wready not held for %0d cycles", addr, b_dly);
    end
    bready = 1;
    @(posedge aclk);
    @(negedge aclk);
    bready = 0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++;
      $display("FAIL wr_b_release addr=%h bvalid=%b awready=%b wready=%b required 0 1 1",
               addr, bvalid, awready, wready);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] prot, input int r_dly,
                         output logic [31:0] data_got, output logic [1:0] resp_got);
    logic [31:0] ed, md;
    logic [1:0]  er, mr;
    int n = 0;
    bit hold_bad = 0;
    model_read(addr, prot, md, mr);
    exp_q.push_back(md);
    exp_resp_q.push_back(mr);
    @(negedge aclk);
    araddr = addr; arprot = prot; arvalid = 1; rready = 0;
    while (!arready && n < 20) begin
      @(posedge aclk);
      @(negedge aclk);
      n++;
    end
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 0;
    ed = exp_q.pop_front();
    er = exp_resp_q.pop_front();
    checks++;
    if (rvalid !== 1'b1 || arready !== 1'b0) begin
      errors++;
      $display("FAIL rd_latency addr=%h rvalid=%b arready=%b required 1 0", addr, rvalid, arready);
    end
    checks++;
    if (rdata !== ed || rresp !== er) begin
      errors++;
      $display("FAIL rd_data addr=%h rdata=%h rresp=%b required %h %b", addr, rdata, rresp, ed, er);
    end
    data_got = rdata;
    resp_got = rresp;
    for (int i = 0; i < r_dly; i++) begin
      @(posedge aclk);
      @(negedge aclk);
      if (rvalid !== 1'b1 || rdata !== ed || rresp !== er || arready !== 1'b0) hold_bad = 1;
    end
    checks++;
    if (hold_bad) begin
      errors++;
      $display("FAIL rd_hold addr=%h R beat not stable for %0d cycles", addr, r_dly);
    end
    rready = 1;
    @(posedge aclk);
    @(negedge aclk);
    rready = 0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++;
      $display("FAIL rd_release addr=%h rvalid=%b arready=%b required 0 1", addr, rvalid, arready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (bvalid !== 0 || rvalid !== 0 || bresp !== OKAY || rresp !== OKAY || rdata !== 32'h0 ||
        awready !== 1 || wready !== 1 || arready !== 1) begin
      errors++;
      $display("FAIL reset_state bv=%b rv=%b br=%b rr=%b rd=%h awr=%b wr=%b arr=%b required 0 0 00 00 0 1 1 1",
               bvalid, rvalid, bresp, rresp, rdata, awready, wready, arready);
    end
    // W alone is held, then reset must drop it.
    @(negedge aclk);
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1;
    @(posedge aclk);
    @(negedge aclk);
    wvalid = 0;
    aresetn = 0;
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1;
    awaddr = 32'h10; awprot = 3'b001; awvalid = 1;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b0 || wready !== 1'b1) begin
      errors++;
      $display("FAIL reset_drops_w bvalid=%b awready=%b wready=%b required 0 0 1", bvalid, awready, wready);
    end
    apply_reset();
  endtask

  task automatic test_same_cycle_aw_w();
    logic [1:0] r; logic [31:0] d;
    do_write(32'h04, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0, 0, r);
    checks++;
    if (r !== OKAY) begin errors++; $display("FAIL t1_bresp got=%b required 00", r); end
    do_read(32'h04, 3'b001, 0, d, r);
    checks++;
    if (d !== 32'hDEADBEEF || r !== OKAY) begin
      errors++; $display("FAIL t1_readback got=%h %b required deadbeef 00", d, r);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r; logic [31:0] d;
    do_write(32'h08, 32'h11223344, 4'hF, 3'b001, 0, 0, 0, r);
    do_write(32'h08, 32'h000000AA, 4'b0001, 3'b001, 3, 0, 0, r);
    do_read(32'h08, 3'b001, 0, d, r);
    checks++;
    if (d !== 32'h112233AA) begin errors++; $display("FAIL t2_strobe got=%h required 112233aa", d); end
    // AW first, W later, upper two bytes only
    do_write(32'h08, 32'h5566_7788, 4'b1100, 3'b001, 0, 2, 0, r);
    do_read(32'h08, 3'b001, 0, d, r);
    checks++;
    if (d !== 32'h556633AA) begin errors++; $display("FAIL t2_upper_strobe got=%h required 556633aa", d); end
    // zero strobe is a no-op that still answers OKAY
    do_write(32'h08, 32'hFFFF_FFFF, 4'b0000, 3'b001, 1, 1, 0, r);
    checks++;
    if (r !== OKAY) begin errors++; $display("FAIL t2_zero_strb_resp got=%b required 00", r); end
    do_read(32'h08, 3'b001, 0, d, r);
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [31:0] d;
    do_write(32'h00, 32'h0BAD_0BAD, 4'hF, 3'b001, 0, 0, 0, r);
    do_write(32'h40, 32'h1234_5678, 4'hF, 3'b001, 0, 0, 0, r);
    checks++;
    if (r !== SLVERR) begin errors++; $display("FAIL t3_wr_slverr got=%b required 10", r); end
    do_read(32'h44, 3'b001, 0, d, r);
    checks++;
    if (d !== 32'h0 || r !== SLVERR) begin errors++; $display("FAIL t3_rd_slverr got=%h %b required 0 10", d, r); end
    do_read(32'h00, 3'b001, 0, d, r);
    checks++;
    if (d !== 32'h0BAD_0BAD) begin errors++; $display("FAIL t3_no_alias got=%h required 0bad0bad", d); end
    do_read(32'h3F, 3'b001, 0, d, r);
  endtask

  task automatic test_bready_stall();
    logic [1:0] r; logic [31:0] d;
    do_write(32'h14, 32'hA5A5_5A5A, 4'hF, 3'b001, 0, 0, 5, r);
    do_write(32'h18, 32'h0F0F_0F0F, 4'hF, 3'b001, 0, 0, 0, r);
    do_read(32'h18, 3'b001, 2, d, r);
  endtask

  task automatic test_same_cycle_read_write();
    logic [1:0] r; logic [31:0] d, ed; logic [1:0] er, junk;
    bit hold_bad = 0;
    do_write(32'h0C, 32'h0000_1111, 4'hF, 3'b001, 0, 0, 0, r);
    model_read(32'h0C, 3'b001, ed, er);
    @(negedge aclk);
    awaddr = 32'h0C; awprot = 3'b001; wdata = 32'h2222_3333; wstrb = 4'hF;
    araddr = 32'h0C; arprot = 3'b001;
    awvalid = 1; wvalid = 1; arvalid = 1; rready = 0;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1;
    junk = model_write(32'h0C, 32'h2222_3333, 4'hF, 3'b001);
    checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== ed) begin
      errors++;
      $display("FAIL t5_old_value bvalid=%b rvalid=%b rdata=%h required 1 1 %h", bvalid, rvalid, rdata, ed);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk);
      @(negedge aclk);
      bready = 0;
      if (rvalid !== 1'b1 || rdata !== ed || rresp !== er) hold_bad = 1;
    end
    checks++;
    if (hold_bad) begin errors++; $display("FAIL t5_hold rdata=%h required %h stable", rdata, ed); end
    rready = 1;
    @(posedge aclk);
    @(negedge aclk);
    rready = 0;
    do_read(32'h0C, 3'b001, 0, d, r);
    checks++;
    if (d !== 32'h2222_3333) begin errors++; $display("FAIL t5_new_value got=%h required 22223333", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] md, ed;
    logic [1:0]  mr, er;
    logic [31:0] a;
    int beats = 0;
    bit data_bad = 0;
    @(negedge aclk);
    rready = 1;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) begin
        @(posedge aclk);
        @(negedge aclk);
        if (rvalid) begin
          beats++;
          ed = exp_q.pop_front();
          er = exp_resp_q.pop_front();
          if (rdata !== ed || rresp !== er) data_bad = 1;
        end
      end
      if (c < 8) begin
        if (arready) begin
          a = 32'($urandom_range(0, 15)) * 4;
          araddr = a; arprot = 3'b001; arvalid = 1;
          model_read(a, 3'b001, md, mr);
          exp_q.push_back(md);
          exp_resp_q.push_back(mr);
        end
      end else begin
        arvalid = 0;
      end
    end
    rready = 0;
    checks++;
    if (beats != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_rate beats=%0d pending=%0d required 4 0", beats, exp_q.size());
    end
    checks++;
    if (data_bad) begin errors++; $display("FAIL b2b_data read data differs from model"); end
    exp_q.delete();
    exp_resp_q.delete();
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [1:0]  r;
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 19)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r);
      else
        do_read(a, 3'($urandom_range(0, 7)), $urandom_range(0, 2), d, r);
    end
  endtask

`ifdef AXI4_LITE_SLAVE_PROT_CHECK_EN
  task automatic test_prot();
    logic [1:0] r; logic [31:0] d;
    do_write(32'h00, 32'h7777_7777, 4'hF, 3'b001, 0, 0, 0, r);
    do_write(32'h00, 32'h1234_5678, 4'hF, 3'b000, 0, 0, 0, r);
    checks++;
    if (r !== SLVERR) begin errors++; $display("FAIL t6_unpriv_wr got=%b required 10", r); end
    do_read(32'h00, 3'b001, 0, d, r);
    checks++;
    if (d !== 32'h7777_7777) begin errors++; $display("FAIL t6_unchanged got=%h required 77777777", d); end
    do_read(32'h00, 3'b000, 0, d, r);
    checks++;
    if (d !== 32'h0 || r !== SLVERR) begin errors++; $display("FAIL t6_unpriv_rd got=%h %b required 0 10", d, r); end
    do_write(32'h00, 32'h1234_5678, 4'hF, 3'b001, 0, 0, 0, r);
    checks++;
    if (r !== OKAY) begin errors++; $display("FAIL t6_priv_wr got=%b required 00", r); end
  endtask
`endif

  initial begin
    test_reset();
    test_same_cycle_aw_w();
    test_w_before_aw();
    test_out_of_range();
    test_bready_stall();
    test_same_cycle_read_write();
    test_back_to_back();
`ifdef AXI4_LITE_SLAVE_PROT_CHECK_EN
    test_prot();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
